// File: rtl/rib_uart_pkg.sv
// Shared definitions for the RIB UART: register offsets, FSM state encoding
// and the BAUD divisor clamp.
package rib_uart_pkg;

  localparam logic [7:0] UART_CTRL   = 8'h00;
  localparam logic [7:0] UART_STATUS = 8'h04;
  localparam logic [7:0] UART_BAUD   = 8'h08;
  localparam logic [7:0] UART_TXDATA = 8'h0C;
  localparam logic [7:0] UART_RXDATA = 8'h10;

  localparam logic [15:0] UART_BAUD_MIN = 16'd4;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  function automatic logic [15:0] clamp_baud(input logic [15:0] value);
    return (value < UART_BAUD_MIN) ? UART_BAUD_MIN : value;
  endfunction

endpackage

// File: rtl/rib_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and first-word-fall-through read data.
module rib_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/rib_uart.sv
// RIB bus slave UART (8N1, LSB first): registers, TX FIFO, single-entry RX
// buffer and a level interrupt.
module rib_uart
  import rib_uart_pkg::*;
#(
  parameter int CPU_WIDTH = 32,
  parameter int TX_DEPTH  = 4,
  parameter int BAUD_RST  = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPU_WIDTH-1:0] addr_i,
  input  logic [CPU_WIDTH-1:0] data_i,
  input  logic                 we_i,
  output logic [CPU_WIDTH-1:0] data_o,
  input  logic                 rx_i,
  output logic                 tx_o,
  output logic                 irq_o
);

  logic [3:0]  ctrl;
  logic [15:0] baud;
  logic        tx_ovf, rx_ovr, rx_ferr, rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  offs;
  logic        wr_ctrl, wr_status, wr_baud, wr_txdata, wr_rxdata;

  assign offs      = addr_i[7:0];
  assign wr_ctrl   = we_i && (offs == UART_CTRL);
  assign wr_status = we_i && (offs == UART_STATUS);
  assign wr_baud   = we_i && (offs == UART_BAUD);
  assign wr_txdata = we_i && (offs == UART_TXDATA);
  assign wr_rxdata = we_i && (offs == UART_RXDATA);

  logic                      tx_pop, tx_full, tx_empty;
  logic [7:0]                tx_head;
  logic [$clog2(TX_DEPTH):0] tx_count;

  rib_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (tx_pop),
    .din   (data_i[7:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  uart_state_t tx_state, tx_state_n, rx_state, rx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]  tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n, rx_shift, rx_shift_n;
  logic        rx_s1, rx_s2, rx_prev;
  logic        tx_busy, tx_end, rx_end, rx_half, rx_fall;
  logic        rx_load, rx_ovr_set, rx_ferr_set;

  assign tx_busy = (tx_state != UART_IDLE);
  assign tx_end  = (tx_cnt == tx_div - 16'd1);
  assign rx_end  = (rx_cnt == rx_div - 16'd1);
  assign rx_half = (rx_cnt == (rx_div >> 1) - 16'd1);
  assign rx_fall = rx_prev & ~rx_s2;
  assign tx_o    = (tx_state == UART_START) ? 1'b0 :
                   (tx_state == UART_DATA)  ? tx_shift[0] : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= UART_IDLE;  tx_cnt <= '0; tx_div <= '0; tx_bit <= '0; tx_shift <= '0;
      rx_state <= UART_IDLE;  rx_cnt <= '0; rx_div <= '0; rx_bit <= '0; rx_shift <= '0;
      rx_s1    <= 1'b1;       rx_s2  <= 1'b1; rx_prev <= 1'b1;
    end else begin
      tx_state <= tx_state_n; tx_cnt <= tx_cnt_n; tx_div <= tx_div_n;
      tx_bit   <= tx_bit_n;   tx_shift <= tx_shift_n;
      rx_state <= rx_state_n; rx_cnt <= rx_cnt_n; rx_div <= rx_div_n;
      rx_bit   <= rx_bit_n;   rx_shift <= rx_shift_n;
      rx_s1    <= rx_i;       rx_s2  <= rx_s1;  rx_prev <= rx_s2;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    case (tx_state)
      UART_IDLE: begin
        tx_cnt_n = '0;
        if (ctrl[0] && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_div_n   = baud;
          tx_bit_n   = '0;
          tx_state_n = UART_START;
        end
      end
      UART_START: if (tx_end) begin
        tx_cnt_n   = '0;
        tx_state_n = UART_DATA;
      end
      UART_DATA: if (tx_end) begin
        tx_cnt_n   = '0;
        tx_shift_n = tx_shift >> 1;
        tx_bit_n   = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_n = UART_STOP;
      end
      UART_STOP: if (tx_end) begin
        tx_cnt_n   = '0;
        tx_state_n = UART_IDLE;
      end
      default: tx_state_n = UART_IDLE;
    endcase
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + 16'd1;
    rx_div_n    = rx_div;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_load     = 1'b0;
    rx_ovr_set  = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      UART_IDLE: begin
        rx_cnt_n = '0;
        if (ctrl[1] && rx_fall) begin
          rx_div_n   = baud;
          rx_bit_n   = '0;
          rx_state_n = UART_START;
        end
      end
      UART_START: if (rx_half) begin
        rx_cnt_n   = '0;
        rx_state_n = rx_s2 ? UART_IDLE : UART_DATA;
      end
      UART_DATA: if (rx_end) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_s2, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_n = UART_STOP;
      end
      UART_STOP: if (rx_end) begin
        rx_cnt_n   = '0;
        rx_state_n = UART_IDLE;
        if (!rx_s2)        rx_ferr_set = 1'b1;
        else if (rx_valid) rx_ovr_set  = 1'b1;
        else               rx_load     = 1'b1;
      end
      default: rx_state_n = UART_IDLE;
    endcase
  end

  logic [CPU_WIDTH-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (offs)
      UART_CTRL:   rd_mux = CPU_WIDTH'(ctrl);
      UART_STATUS: rd_mux = CPU_WIDTH'({rx_ferr, rx_ovr, tx_ovf, rx_valid, tx_busy, tx_empty, tx_full});
      UART_BAUD:   rd_mux = CPU_WIDTH'(baud);
      UART_RXDATA: rd_mux = CPU_WIDTH'(rx_data);
      default:     rd_mux = '0;
    endcase
  end

  // Flag sets take priority over W1C / pop writes in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      baud     <= 16'(BAUD_RST);
      tx_ovf   <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      data_o   <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= data_i[3:0];
      if (wr_baud) baud <= clamp_baud(data_i[15:0]);
      if (rx_load) rx_data <= rx_shift;
      tx_ovf   <= (wr_txdata & tx_full & ~tx_pop) | (tx_ovf & ~(wr_status & data_i[4]));
      rx_ovr   <= rx_ovr_set  | (rx_ovr  & ~(wr_status & data_i[5]));
      rx_ferr  <= rx_ferr_set | (rx_ferr & ~(wr_status & data_i[6]));
      rx_valid <= rx_load | (rx_valid & ~wr_rxdata);
      data_o   <= rd_mux;
      irq_o    <= (ctrl[2] & tx_empty & ~tx_busy) | (ctrl[3] & rx_valid);
    end
  end

endmodule

// File: tb/tb_rib_uart.sv
// Self-checking bench for rib_uart: register vector table, scoreboarded bus
// reads, and hand sequences for TX timing, FIFO overflow, RX, glitch and IRQ.
module tb_rib_uart;
  import rib_uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i, data_i, data_o;
  logic        we_i, rx_i, tx_o, irq_o;

  rib_uart #(.CPU_WIDTH(32), .TX_DEPTH(4), .BAUD_RST(434)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .we_i(we_i),
    .data_o(data_o), .rx_i(rx_i), .tx_o(tx_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { string name; logic [31:0] exp; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = {24'b0, a}; data_i = d; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic read_expect(input logic [7:0] a, input logic [31:0] e, input string n);
    exp_t x;
    x.name = n; x.exp = e;
    sb.push_back(x);
    @(negedge clk);
    addr_i = {24'b0, a}; we_i = 1'b0;
    @(negedge clk);
    x = sb.pop_front();
    check(x.name, data_o, x.exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
    rx_i = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (per) @(negedge clk);
    end
    rx_i = stop;
    repeat (per) @(negedge clk);
    rx_i = 1'b1;
    repeat (per) @(negedge clk);
  endtask

  task automatic wait_tx_low(input string n);
    int t = 0;
    while (tx_o !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check(n, {31'b0, tx_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] tx_byte;
    logic       exp_bit;

    vt[0] = '{UART_CTRL,   1'b1, 32'h0000_005A, 32'h0000_000A, "ctrl_rw"};
    vt[1] = '{UART_CTRL,   1'b1, 32'h0000_0000, 32'h0000_0000, "ctrl_clear"};
    vt[2] = '{UART_BAUD,   1'b1, 32'h0001_2345, 32'h0000_2345, "baud_rw"};
    vt[3] = '{UART_BAUD,   1'b1, 32'h0000_0002, 32'h0000_0004, "baud_clamp2"};
    vt[4] = '{UART_BAUD,   1'b1, 32'h0000_0003, 32'h0000_0004, "baud_clamp3"};
    vt[5] = '{UART_BAUD,   1'b1, 32'h0000_0005, 32'h0000_0005, "baud_5"};
    vt[6] = '{8'h14,       1'b1, 32'hFFFF_FFFF, 32'h0000_0000, "unmapped"};
    vt[7] = '{UART_TXDATA, 1'b0, 32'h0000_0000, 32'h0000_0000, "txdata_read"};
    vt[8] = '{UART_RXDATA, 1'b0, 32'h0000_0000, 32'h0000_0000, "rxdata_reset"};
    vt[9] = '{UART_STATUS, 1'b1, 32'h0000_007F, 32'h0000_0002, "status_w1c_idle"};

    rst = 1'b1; rx_i = 1'b1; we_i = 1'b0; addr_i = '0; data_i = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_o", {31'b0, tx_o}, 32'd1);
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    check("rst_data_o", data_o, 32'd0);
    rst = 1'b0;
    read_expect(UART_STATUS, 32'h2, "rst_status");
    read_expect(UART_BAUD, 32'd434, "rst_baud");

    foreach (vt[i]) begin
      if (vt[i].we) bus_write(vt[i].addr, vt[i].wdata);
      read_expect(vt[i].addr, vt[i].exp, vt[i].name);
    end

    // TX frame 0xA5 at BAUD=8, checked every cycle.
    tx_byte = 8'hA5;
    bus_write(UART_BAUD, 32'd8);
    bus_write(UART_CTRL, 32'h1);
    bus_write(UART_TXDATA, {24'b0, tx_byte});
    addr_i = {24'b0, UART_STATUS};
    wait_tx_low("tx_start_seen");
    for (int i = 0; i < 80; i++) begin
      if (i < 8)       exp_bit = 1'b0;
      else if (i < 72) exp_bit = tx_byte[(i - 8) / 8];
      else             exp_bit = 1'b1;
      check($sformatf("tx_bit_cycle%0d", i), {31'b0, tx_o}, {31'b0, exp_bit});
      if (i == 40) check("tx_busy_mid", {31'b0, data_o[2]}, 32'd1);
      @(negedge clk);
    end
    read_expect(UART_STATUS, 32'h2, "tx_done_status");

    // Mid-frame reset forces the line high immediately.
    bus_write(UART_TXDATA, 32'h00);
    wait_tx_low("tx2_start_seen");
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midframe_rst_tx_o", {31'b0, tx_o}, 32'd1);
    @(negedge clk);
    check("midframe_rst_data_o", data_o, 32'd0);
    rst = 1'b0;
    read_expect(UART_STATUS, 32'h2, "midframe_rst_status");
    read_expect(UART_BAUD, 32'd434, "midframe_rst_baud");
    read_expect(UART_CTRL, 32'd0, "midframe_rst_ctrl");

    // FIFO fill and overflow with TX disabled.
    for (int i = 0; i < 4; i++) bus_write(UART_TXDATA, 32'h10 + i);
    read_expect(UART_STATUS, 32'h01, "fifo_full");
    bus_write(UART_TXDATA, 32'h99);
    read_expect(UART_STATUS, 32'h11, "fifo_ovf");
    bus_write(UART_STATUS, 32'h10);
    read_expect(UART_STATUS, 32'h01, "fifo_ovf_w1c");
    bus_write(UART_BAUD, 32'd4);
    bus_write(UART_CTRL, 32'h1);
    repeat (200) @(negedge clk);
    read_expect(UART_STATUS, 32'h02, "fifo_drained");
    bus_write(UART_CTRL, 32'h5);
    repeat (2) @(negedge clk);
    check("tx_irq_on", {31'b0, irq_o}, 32'd1);
    bus_write(UART_CTRL, 32'h0);
    repeat (2) @(negedge clk);
    check("tx_irq_off", {31'b0, irq_o}, 32'd0);

    // RX at BAUD=16: receive, overrun, pop, W1C.
    bus_write(UART_BAUD, 32'd16);
    bus_write(UART_CTRL, 32'h2);
    send_frame(8'h3C, 1'b1, 16);
    read_expect(UART_STATUS, 32'h0A, "rx_valid");
    read_expect(UART_RXDATA, 32'h3C, "rx_data");
    send_frame(8'hC3, 1'b1, 16);
    read_expect(UART_STATUS, 32'h2A, "rx_ovr");
    read_expect(UART_RXDATA, 32'h3C, "rx_data_kept");
    bus_write(UART_RXDATA, 32'h0);
    read_expect(UART_STATUS, 32'h22, "rx_pop");
    bus_write(UART_STATUS, 32'h20);
    read_expect(UART_STATUS, 32'h02, "rx_ovr_w1c");

    // Glitch shorter than half a bit, then a framing error.
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    read_expect(UART_STATUS, 32'h02, "rx_glitch");
    send_frame(8'h81, 1'b0, 16);
    read_expect(UART_STATUS, 32'h42, "rx_ferr");
    read_expect(UART_RXDATA, 32'h3C, "rx_ferr_data");
    bus_write(UART_STATUS, 32'h40);
    read_expect(UART_STATUS, 32'h02, "rx_ferr_w1c");

    // RX interrupt: asserted on receive, gone two cycles after the pop.
    bus_write(UART_CTRL, 32'hA);
    repeat (2) @(negedge clk);
    check("rx_irq_idle", {31'b0, irq_o}, 32'd0);
    send_frame(8'h5A, 1'b1, 16);
    check("rx_irq_on", {31'b0, irq_o}, 32'd1);
    read_expect(UART_RXDATA, 32'h5A, "rx_irq_data");
    bus_write(UART_RXDATA, 32'h0);
    check("rx_irq_hold", {31'b0, irq_o}, 32'd1);
    @(negedge clk);
    check("rx_irq_off", {31'b0, irq_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
